// File: rtl/reset_sys.sv
// reset_sys: lock-qualified staged reset sequencer; waits for stable PLL lock, then releases rst_out bit by bit.
// Optional lock watchdog with PLL restart pulse is enabled by defining RESET_SYS_TIMEOUT_EN.
module reset_sys #(
    parameter int HOLD_CYCLES    = 1024,
    parameter int STAGES         = 3,
    parameter int STAGE_GAP      = 16,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              locked,
    output logic [STAGES-1:0] rst_out,
    output logic              ready,
    output logic              pll_rst,
    output logic [7:0]        lost_cnt
);
    localparam int MAX_HG = HOLD_CYCLES > STAGE_GAP ? HOLD_CYCLES : STAGE_GAP;
    localparam int MAX_C  = MAX_HG > TIMEOUT_CYCLES ? MAX_HG : TIMEOUT_CYCLES;
    localparam int CW     = $clog2(MAX_C + 9);
    localparam int IW     = STAGES > 1 ? $clog2(STAGES) : 1;

    typedef enum logic [2:0] {WAIT_LOCK, HOLD, RELEASE, RUN, RESTART} state_t;

    state_t            state, state_n;
    logic [1:0]        sync;
    logic              locked_s;
    logic [CW-1:0]     cnt, cnt_n;
    logic [IW-1:0]     idx, idx_n;
    logic [STAGES-1:0] rst_out_n;
    logic              ready_n, pll_rst_n;
    logic [7:0]        lost_n;

    assign locked_s = sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync     <= '0;
            state    <= WAIT_LOCK;
            cnt      <= '0;
            idx      <= '0;
            rst_out  <= '1;
            ready    <= 1'b0;
            pll_rst  <= 1'b0;
            lost_cnt <= '0;
        end else begin
            sync     <= {sync[0], locked};
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            rst_out  <= rst_out_n;
            ready    <= ready_n;
            pll_rst  <= pll_rst_n;
            lost_cnt <= lost_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        rst_out_n = rst_out;
        ready_n   = ready;
        pll_rst_n = 1'b0;
        lost_n    = lost_cnt;
        if ((state == RELEASE || state == RUN) && !locked_s) begin
            // Loss takes priority over any stage clear due this cycle
            state_n   = WAIT_LOCK;
            cnt_n     = '0;
            idx_n     = '0;
            rst_out_n = '1;
            ready_n   = 1'b0;
            lost_n    = lost_cnt + {7'd0, ~&lost_cnt};
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_n = HOLD;
                        cnt_n   = '0;
`ifdef RESET_SYS_TIMEOUT_EN
                    end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        state_n   = RESTART;
                        cnt_n     = '0;
                        pll_rst_n = 1'b1;
                    end else begin
                        cnt_n = cnt + CW'(1);
`else
                    end else begin
                        cnt_n = &cnt ? cnt : cnt + CW'(1);
`endif
                    end
                end
                HOLD: begin
                    if (!locked_s) begin
                        state_n = WAIT_LOCK;
                        cnt_n   = '0;
                    end else if (cnt == CW'(HOLD_CYCLES - 1)) begin
                        state_n = RELEASE;
                        cnt_n   = '0;
                        idx_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                RELEASE: begin
                    if (cnt == CW'(STAGE_GAP - 1)) begin
                        rst_out_n[idx] = 1'b0;
                        cnt_n          = '0;
                        if (idx == IW'(STAGES - 1)) begin
                            ready_n = 1'b1;
                            state_n = RUN;
                        end else begin
                            idx_n = idx + IW'(1);
                        end
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                RUN: state_n = RUN;
`ifdef RESET_SYS_TIMEOUT_EN
                RESTART: begin
                    if (cnt == CW'(7)) begin
                        state_n = WAIT_LOCK;
                        cnt_n   = '0;
                    end else begin
                        pll_rst_n = 1'b1;
                        cnt_n     = cnt + CW'(1);
                    end
                end
`endif
                default: begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end
            endcase
        end
    end
endmodule
